// File: rtl/serdes_link_ctrl.sv
// serdes_link_ctrl
//   SERDES bring-up sequencer: pulses the PLL reset, then the TX/RX reset,
//   waits for reset-done and byte alignment (optionally an error-free PRBS
//   window), then reports link-up. Failed attempts are retried up to a
//   limit, after which the controller parks in FAIL until restarted.
//
//   Optional feature: define SERDES_LINK_CTRL_PRBS_EN to insert the PRBS_CHK
//   state between WAIT_ALIGN and LINK_UP. Without it prbs_cnt_reset_o is
//   held at 0 and rx_prbs_err_i is ignored.
//
// Ports
//   clk_i              controller clock
//   rst_i              asynchronous active-high reset
//   tx_reset_done_i    SERDES TX reset done        (asynchronous)
//   rx_reset_done_i    SERDES RX reset done        (asynchronous)
//   rx_byte_aligned_i  RX byte alignment achieved  (asynchronous)
//   rx_buf_err_i       RX elastic buffer error     (asynchronous)
//   rx_prbs_err_i      RX PRBS checker error       (asynchronous)
//   restart_i          synchronous restart request
//   pll_rst_o          PLL reset
//   trx_rst_o          TX/RX reset
//   prbs_cnt_reset_o   PRBS error counter reset
//   link_up_o          link is up
//   fail_o             bring-up abandoned
//   state_o[2:0]       current state code
//   retry_cnt_o[3:0]   consecutive failed attempts
//
// state      | meaning
// PLL_RST    | PLL and TX/RX held in reset for RST_HOLD cycles
// TRX_RST    | TX/RX held in reset for RST_HOLD cycles
// WAIT_DONE  | waiting for TX and RX reset-done
// WAIT_ALIGN | waiting for RX byte alignment
// PRBS_CHK   | waiting for PRBS_WIN consecutive error-free cycles
// LINK_UP    | link operational, watching for loss of alignment/buffer error
// FAIL       | retry budget exhausted, waiting for restart

module serdes_link_ctrl #(
    parameter int RST_HOLD  = 16,
    parameter int TIMEOUT   = 65535,
    parameter int MAX_RETRY = 3,
    parameter int PRBS_WIN  = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_reset_done_i,
    input  logic       rx_reset_done_i,
    input  logic       rx_byte_aligned_i,
    input  logic       rx_buf_err_i,
    input  logic       rx_prbs_err_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       trx_rst_o,
    output logic       prbs_cnt_reset_o,
    output logic       link_up_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt_o
);

    typedef enum logic [2:0] {
        ST_PLL_RST    = 3'd0,
        ST_TRX_RST    = 3'd1,
        ST_WAIT_DONE  = 3'd2,
        ST_WAIT_ALIGN = 3'd3,
        ST_PRBS_CHK   = 3'd4,
        ST_LINK_UP    = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    // Two-flop synchronizers for every SERDES status input.
    logic [4:0] sync_meta;
    logic [4:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {tx_reset_done_i, rx_reset_done_i, rx_byte_aligned_i,
                          rx_buf_err_i, rx_prbs_err_i};
            sync_q    <= sync_meta;
        end
    end

    logic tx_done_s;
    logic rx_done_s;
    logic aligned_s;
    logic buf_err_s;

    assign tx_done_s = sync_q[4];
    assign rx_done_s = sync_q[3];
    assign aligned_s = sync_q[2];
    assign buf_err_s = sync_q[1];

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] cnt_inc;
    logic [3:0]  retry_nxt;
    logic [3:0]  retry_inc;
    logic        attempt_failed;

`ifdef SERDES_LINK_CTRL_PRBS_EN
    // The shared counter measures total time in PRBS_CHK (for the timeout);
    // win_cnt measures the current error-free run, restarted by each error.
    localparam logic [15:0] PRBS_LIMIT = 16'(TIMEOUT);
    localparam logic [15:0] WIN_LAST   = 16'(PRBS_WIN - 1);

    logic        prbs_err_s;
    logic [15:0] win_cnt;
    logic [15:0] win_nxt;

    assign prbs_err_s = sync_q[0];
`else
    logic [15:0] unused_cfg;
    assign unused_cfg = 16'(PRBS_WIN) ^ {15'd0, sync_q[0]};
`endif

    // Counter saturates instead of wrapping (long stays in LINK_UP/FAIL).
    assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign retry_inc = retry_cnt_o + 4'd1;

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt_inc;
        retry_nxt      = retry_cnt_o;
        attempt_failed = 1'b0;
`ifdef SERDES_LINK_CTRL_PRBS_EN
        win_nxt        = win_cnt;
`endif
        if (restart_i) begin
            state_nxt = ST_PLL_RST;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == HOLD_LAST) state_nxt = ST_TRX_RST;
                end
                ST_TRX_RST: begin
                    if (cnt == HOLD_LAST) state_nxt = ST_WAIT_DONE;
                end
                // Timeout is tested first so it wins over a same-cycle success.
                ST_WAIT_DONE: begin
                    if (cnt == WAIT_LAST)             attempt_failed = 1'b1;
                    else if (tx_done_s && rx_done_s)  state_nxt = ST_WAIT_ALIGN;
                end
                ST_WAIT_ALIGN: begin
                    if (cnt == WAIT_LAST) begin
                        attempt_failed = 1'b1;
                    end else if (aligned_s) begin
`ifdef SERDES_LINK_CTRL_PRBS_EN
                        state_nxt = ST_PRBS_CHK;
`else
                        state_nxt = ST_LINK_UP;
`endif
                    end
                end
`ifdef SERDES_LINK_CTRL_PRBS_EN
                // First cycle only clears the external error counter; the
                // error-free run is counted from the second cycle on.
                ST_PRBS_CHK: begin
                    if (cnt == PRBS_LIMIT) begin
                        attempt_failed = 1'b1;
                    end else if (cnt != 16'd0) begin
                        if (prbs_err_s)               win_nxt = '0;
                        else if (win_cnt == WIN_LAST) state_nxt = ST_LINK_UP;
                        else                          win_nxt = win_cnt + 16'd1;
                    end
                end
`endif
                ST_LINK_UP: begin
                    if (!aligned_s || buf_err_s) state_nxt = ST_TRX_RST;
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_PLL_RST;
                end
            endcase

            if (attempt_failed) begin
                retry_nxt = retry_inc;
                state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_TRX_RST;
            end
        end

        if (restart_i || (state_nxt != state)) begin
            cnt_nxt = '0;
`ifdef SERDES_LINK_CTRL_PRBS_EN
            win_nxt = '0;
`endif
        end

        if ((state_nxt == ST_LINK_UP) && (state != ST_LINK_UP)) retry_nxt = '0;
    end

    // Outputs are decoded from the next state so they change together with state_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_PLL_RST;
            cnt              <= '0;
            retry_cnt_o      <= '0;
            pll_rst_o        <= 1'b1;
            trx_rst_o        <= 1'b1;
            prbs_cnt_reset_o <= 1'b0;
            link_up_o        <= 1'b0;
            fail_o           <= 1'b0;
`ifdef SERDES_LINK_CTRL_PRBS_EN
            win_cnt          <= '0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_cnt_o <= retry_nxt;
            pll_rst_o   <= (state_nxt == ST_PLL_RST);
            trx_rst_o   <= (state_nxt inside {ST_PLL_RST, ST_TRX_RST, ST_FAIL});
            link_up_o   <= (state_nxt == ST_LINK_UP);
            fail_o      <= (state_nxt == ST_FAIL);
`ifdef SERDES_LINK_CTRL_PRBS_EN
            win_cnt          <= win_nxt;
            prbs_cnt_reset_o <= (state_nxt == ST_PRBS_CHK) && (state != ST_PRBS_CHK);
`else
            prbs_cnt_reset_o <= 1'b0;
`endif
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
module tb_serdes_link_ctrl;

    localparam int H  = 4;
    localparam int MR = 3;
    localparam int PW = 8;
`ifdef SERDES_LINK_CTRL_PRBS_EN
    localparam int TO   = 30;
    localparam bit PRBS = 1'b1;
`else
    localparam int TO   = 10;
    localparam bit PRBS = 1'b0;
`endif
    localparam int NOM_LEN = 2 * H + PW + 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic       aligned = 1'b0;
    logic       buf_err = 1'b0;
    logic       prbs_err = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst_o;
    logic       trx_rst_o;
    logic       prbs_cnt_reset_o;
    logic       link_up_o;
    logic       fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_cnt_o;
    logic [11:0] dut_vec;

    serdes_link_ctrl #(
        .RST_HOLD (H),
        .TIMEOUT  (TO),
        .MAX_RETRY(MR),
        .PRBS_WIN (PW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .tx_reset_done_i  (tx_done),
        .rx_reset_done_i  (rx_done),
        .rx_byte_aligned_i(aligned),
        .rx_buf_err_i     (buf_err),
        .rx_prbs_err_i    (prbs_err),
        .restart_i        (restart),
        .pll_rst_o        (pll_rst_o),
        .trx_rst_o        (trx_rst_o),
        .prbs_cnt_reset_o (prbs_cnt_reset_o),
        .link_up_o        (link_up_o),
        .fail_o           (fail_o),
        .state_o          (state_o),
        .retry_cnt_o      (retry_cnt_o)
    );

    assign dut_vec = {state_o, pll_rst_o, trx_rst_o, prbs_cnt_reset_o,
                      link_up_o, fail_o, retry_cnt_o};

    initial forever #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: state code, cycles spent in it, error-free PRBS run,
    // retry count, and the input samples still travelling through the
    // synchronizers.
    int         m_state, m_age, m_clean, m_retry;
    logic [4:0] hist0, hist1;

    function automatic logic [11:0] model_outs();
        logic [11:0] v;
        v[11:9] = 3'(m_state);
        v[8]    = (m_state == 0);
        v[7]    = (m_state == 0) || (m_state == 1) || (m_state == 6);
        v[6]    = (m_state == 4) && (m_age == 0);
        v[5]    = (m_state == 5);
        v[4]    = (m_state == 6);
        v[3:0]  = 4'(m_retry);
        return v;
    endfunction

    task automatic m_enter(input int s);
        m_state = s;
        m_age   = 0;
        m_clean = 0;
        if (s == 5) m_retry = 0;
    endtask

    task automatic m_failed();
        m_retry++;
        if (m_retry == MR) m_enter(6);
        else m_enter(1);
    endtask

    task automatic model_step();
        logic [4:0] seen;
        seen  = hist1;
        hist1 = hist0;
        hist0 = {tx_done, rx_done, aligned, buf_err, prbs_err};
        if (restart) begin
            m_enter(0);
            m_retry = 0;
        end else begin
            case (m_state)
                0: if (m_age + 1 == H) m_enter(1); else m_age++;
                1: if (m_age + 1 == H) m_enter(2); else m_age++;
                2: begin
                    if (m_age + 1 >= TO) m_failed();
                    else if (seen[4] && seen[3]) m_enter(3);
                    else m_age++;
                end
                3: begin
                    if (m_age + 1 >= TO) m_failed();
                    else if (seen[2]) m_enter(PRBS ? 4 : 5);
                    else m_age++;
                end
                4: begin
                    if (m_age + 1 > TO) m_failed();
                    else begin
                        if (m_age > 0) m_clean = seen[0] ? 0 : m_clean + 1;
                        if (m_clean == PW) m_enter(5);
                        else m_age++;
                    end
                end
                5: if (!seen[2] || seen[1]) m_enter(1); else m_age++;
                default: m_age++;
            endcase
        end
    endtask

    task automatic tick(input string tag = "cycle");
        @(posedge clk);
        if (!rst) model_step();
        #2;
        check(tag, dut_vec, model_outs());
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        m_enter(0);
        m_retry = 0;
        hist0 = '0;
        hist1 = '0;
        #1;
        check("async_reset", dut_vec, model_outs());
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_release", dut_vec, model_outs());
    endtask

    task automatic set_in(input logic [4:0] v);
        {tx_done, rx_done, aligned, buf_err, prbs_err} = v;
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        for (int n = 0; n < budget && int'(state_o) != s; n++) tick(tag);
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic wait_retry(input int r, input int budget, input string tag);
        for (int n = 0; n < budget && int'(retry_cnt_o) != r; n++) tick(tag);
        check(tag, 32'(retry_cnt_o), 32'(r));
    endtask

    typedef struct {
        logic [4:0] stim;
        logic [2:0] st;
        logic       pll;
        logic       trx;
        logic       link;
    } nom_t;

    nom_t nom [NOM_LEN];

    initial begin
        int pll_cnt, trx_cnt, prev, seen4;
        int steps[$];

        // Nominal bring-up expectations, by clock edge after reset release.
        for (int i = 0; i < NOM_LEN; i++) begin
            int e;
            e = i + 1;
            nom[i].stim = {4'b1110, ~PRBS};
            if (e < H)                                nom[i].st = 3'd0;
            else if (e < 2 * H)                       nom[i].st = 3'd1;
            else if (e == 2 * H)                      nom[i].st = 3'd2;
            else if (e == 2 * H + 1)                  nom[i].st = 3'd3;
            else if (PRBS && (e < 2 * H + 3 + PW))    nom[i].st = 3'd4;
            else                                      nom[i].st = 3'd5;
            nom[i].pll  = (e < H);
            nom[i].trx  = (e < 2 * H);
            nom[i].link = (nom[i].st == 3'd5);
        end

        // Reset state.
        #1;
        set_in(nom[0].stim);
        reset_pulse();
        check("reset_values", 32'(dut_vec), 32'(12'b000_1_1_0_0_0_0000));

        // Nominal bring-up.
        pll_cnt = int'(pll_rst_o);
        trx_cnt = int'(trx_rst_o);
        for (int i = 0; i < NOM_LEN; i++) begin
            set_in(nom[i].stim);
            tick("nominal");
            check("nominal_tbl", 32'({state_o, pll_rst_o, trx_rst_o, link_up_o}),
                  32'({nom[i].st, nom[i].pll, nom[i].trx, nom[i].link}));
            pll_cnt += int'(pll_rst_o);
            trx_cnt += int'(trx_rst_o);
        end
        check("pll_hold_cycles", 32'(pll_cnt), 32'(H));
        check("trx_hold_cycles", 32'(trx_cnt), 32'(2 * H));

        // Link loss: one-cycle buffer error.
        buf_err = 1'b1;
        tick("loss");
        buf_err = 1'b0;
        tick("loss");
        check("loss_still_up", 32'(state_o), 32'd5);
        tick("loss");
        check("loss_trx", 32'({state_o, link_up_o, retry_cnt_o}), 32'({3'd1, 1'b0, 4'd0}));
        wait_state(5, 100, "relink");

        // Retry exhaustion with RX reset-done stuck low.
        rx_done = 1'b0;
        restart = 1'b1;
        tick("restart");
        restart = 1'b0;
        check("restart_clear", 32'({state_o, retry_cnt_o}), 32'({3'd0, 4'd0}));
        prev = 0;
        for (int n = 0; n < 400 && state_o != 3'd6; n++) begin
            tick("exhaust");
            if (int'(retry_cnt_o) != prev) steps.push_back(int'(retry_cnt_o));
            prev = int'(retry_cnt_o);
        end
        check("retry_steps_n", 32'(steps.size()), 32'd3);
        for (int i = 0; i < steps.size(); i++) check("retry_step", 32'(steps[i]), 32'(i + 1));
        check("fail_state", 32'({state_o, fail_o, trx_rst_o, retry_cnt_o}),
              32'({3'd6, 1'b1, 1'b1, 4'd3}));
        rx_done = 1'b1;
        for (int n = 0; n < 20; n++) tick("fail_hold");
        check("fail_sticky", 32'(state_o), 32'd6);

        // Restart wins over a same-cycle timeout.
        rx_done = 1'b0;
        restart = 1'b1;
        tick("restart");
        restart = 1'b0;
        wait_state(2, 50, "to_wait_done");
        wait_retry(1, 50, "first_timeout");
        wait_state(2, 50, "to_wait_done2");
        for (int n = 0; n < TO - 1; n++) tick("wait_done");
        check("pre_timeout", 32'({state_o, retry_cnt_o}), 32'({3'd2, 4'd1}));
        restart = 1'b1;
        tick("restart_vs_timeout");
        restart = 1'b0;
        check("restart_priority", 32'({state_o, retry_cnt_o, pll_rst_o}),
              32'({3'd0, 4'd0, 1'b1}));

        // Async reset while in WAIT_ALIGN with a nonzero retry count.
        rx_done = 1'b1;
        aligned = 1'b0;
        wait_state(3, 50, "to_align");
        wait_retry(1, 50, "align_timeout");
        wait_state(3, 50, "to_align2");
        tick("align");
        tick("align");
        reset_pulse();
        check("rst_in_align", 32'({state_o, retry_cnt_o, pll_rst_o}), 32'({3'd0, 4'd0, 1'b1}));
        pll_cnt = int'(pll_rst_o);
        for (int n = 0; n < H + 2; n++) begin
            tick("post_rst");
            pll_cnt += int'(pll_rst_o);
        end
        check("pll_hold_after_rst", 32'(pll_cnt), 32'(H));

`ifdef SERDES_LINK_CTRL_PRBS_EN
        // PRBS window restarted by an error after 5 clean cycles.
        set_in(5'b11100);
        restart = 1'b1;
        tick("restart");
        restart = 1'b0;
        wait_state(4, 100, "to_prbs");
        check("prbs_cnt_reset_first", 32'(prbs_cnt_reset_o), 32'd1);
        tick("prbs");
        check("prbs_cnt_reset_once", 32'(prbs_cnt_reset_o), 32'd0);
        for (int n = 0; n < 3; n++) tick("prbs");
        prbs_err = 1'b1;
        tick("prbs");
        prbs_err = 1'b0;
        for (int n = 6; n <= 14; n++) begin
            tick("prbs");
            check("prbs_window_restarted", 32'(state_o), 32'd4);
        end
        tick("prbs");
        check("prbs_link_up", 32'({state_o, link_up_o}), 32'({3'd5, 1'b1}));
`endif

        // Randomized stimulus against the reference model.
        seen4 = 0;
        for (int seg = 0; seg < 12; seg++) begin
            int unsigned p_done, p_align, p_buf, p_err;
            p_done  = $urandom_range(70, 100);
            p_align = $urandom_range(60, 100);
            p_buf   = $urandom_range(0, 4);
            p_err   = $urandom_range(0, 15);
            for (int c = 0; c < 250; c++) begin
                tx_done  = ($urandom_range(0, 99) < p_done);
                rx_done  = ($urandom_range(0, 99) < p_done);
                aligned  = ($urandom_range(0, 99) < p_align);
                buf_err  = ($urandom_range(0, 99) < p_buf);
                prbs_err = ($urandom_range(0, 99) < p_err);
                restart  = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 999) == 0) reset_pulse();
                else tick("random");
                if (state_o == 3'd4 || prbs_cnt_reset_o) seen4++;
            end
        end
        restart = 1'b0;
`ifndef SERDES_LINK_CTRL_PRBS_EN
        check("no_prbs_activity", 32'(seen4), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
